mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between the instruction-fetch requester (IF) and the load/store requester (LSU).
- One transaction is outstanding at a time. Data requests have priority, with an anti-starvation counter for fetch.
- Produces the instr_stall_o / data_stall_o signals consumed by the pipeline controller's memory-stall logic.
- Sits between the IF/LSU stages and the external memory bus, which uses a req/gnt/rvalid handshake.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one req/gnt/rvalid bus port between instruction fetch and the LSU.
// One transaction outstanding at a time; data has priority, fetch is protected by a starve counter.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_err_i,
  output logic                instr_stall_o,
  output logic                data_stall_o,
  output logic                busy_o
);

  localparam int unsigned BeW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;
  typedef enum logic [1:0] {OwnNone, OwnInstr, OwnData} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic              we_q, we_d;
  logic [BeW-1:0]    be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic instr_wins;
  logic resp_fire;
  logic owner_wait;

  assign instr_wins = instr_req_i & (~data_req_i | (starve_q == 4'(STARVE_LIMIT)));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (instr_req_i | data_req_i) begin
          state_d = StReq;
          if (instr_wins) begin
            owner_d = OwnInstr;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = instr_addr_i;
            wdata_d = '0;
          end else begin
            owner_d = OwnData;
            we_d    = data_we_i;
            be_d    = data_be_i;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
          end
        end
        // Count only data wins taken while fetch was pending.
        if (!instr_req_i || instr_wins) begin
          starve_d = '0;
        end else if (starve_q != 4'(STARVE_LIMIT)) begin
          starve_d = starve_q + 4'd1;
        end
      end
      StReq: begin
        if (mem_gnt_i) state_d = StResp;
      end
      StResp: begin
        if (mem_rvalid_i) begin
          state_d = StIdle;
          owner_d = OwnNone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      owner_q  <= OwnNone;
      starve_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_req_o   = (state_q == StReq);
  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != StIdle);

  assign resp_fire  = (state_q == StResp) & mem_rvalid_i;
  // The owner is still waiting from selection until its response arrives.
  assign owner_wait = (state_q != StIdle) & ~resp_fire;

  assign instr_gnt_o    = mem_req_o & (owner_q == OwnInstr) & mem_gnt_i;
  assign data_gnt_o     = mem_req_o & (owner_q == OwnData) & mem_gnt_i;
  assign instr_rvalid_o = resp_fire & (owner_q == OwnInstr);
  assign data_rvalid_o  = resp_fire & (owner_q == OwnData);
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_err_o     = data_rvalid_o & mem_err_i;
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;

  assign instr_stall_o = (instr_req_i & ~instr_gnt_o) | ((owner_q == OwnInstr) & owner_wait);
  assign data_stall_o  = (data_req_i & ~data_gnt_o) | ((owner_q == OwnData) & owner_wait);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LIM = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [AW-1:0] instr_addr;
  logic [DW-1:0] instr_rdata;
  logic data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [DW/8-1:0] data_be;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic instr_stall, data_stall, busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .instr_stall_o(instr_stall), .data_stall_o(data_stall), .busy_o(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req = 0; instr_addr = '0;
    data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #2;
    total++;
    if ({busy, mem_req, instr_gnt, instr_rvalid, instr_err, data_gnt, data_rvalid, data_err,
         instr_stall, data_stall} !== 10'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 0", {busy, mem_req, instr_gnt, instr_rvalid,
               instr_err, data_gnt, data_rvalid, data_err, instr_stall, data_stall});
    end
    total++;
    if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_fields: got %h want 0", {mem_we, mem_be, mem_addr, mem_wdata});
    end
    tick();
  endtask

  task automatic test_lone_fetch();
    instr_req = 1; instr_addr = 32'h0000_0100;
    #2;
    total++;
    if (instr_stall !== 1 || mem_req !== 0) begin
      bad++; $display("FAIL fetch_c0: stall=%b req=%b want 1,0", instr_stall, mem_req);
    end
    tick();
    mem_gnt = 1;
    #2;
    total++;
    if (mem_req !== 1 || mem_addr !== 32'h100 || instr_gnt !== 1 || instr_stall !== 1) begin
      bad++;
      $display("FAIL fetch_c1: req=%b addr=%h gnt=%b stall=%b want 1,100,1,1",
               mem_req, mem_addr, instr_gnt, instr_stall);
    end
    tick();
    instr_req = 0; mem_gnt = 0;
    #2;
    total++;
    if (instr_stall !== 1 || instr_rvalid !== 0 || busy !== 1) begin
      bad++; $display("FAIL fetch_c2: stall=%b rvalid=%b busy=%b want 1,0,1",
                      instr_stall, instr_rvalid, busy);
    end
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #2;
    total++;
    if (instr_rvalid !== 1 || instr_rdata !== 32'h13 || instr_err !== 0 || instr_stall !== 0) begin
      bad++; $display("FAIL fetch_c3: rvalid=%b rdata=%h err=%b stall=%b want 1,13,0,0",
                      instr_rvalid, instr_rdata, instr_err, instr_stall);
    end
    tick();
    idle_inputs();
    #2;
    total++;
    if (busy !== 0) begin bad++; $display("FAIL fetch_done: busy=%b want 0", busy); end
    tick();
  endtask

  task automatic test_contention();
    int n = 0;
    int streak = 0;
    logic exp_i;
    instr_req = 1; instr_addr = 32'h300; data_req = 1; data_addr = 32'h400; data_be = '1;
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h55;
    for (int c = 0; c < 40 && n < 10; c++) begin
      #2;
      if (instr_gnt || data_gnt) begin
        exp_i = (streak == LIM);
        streak = exp_i ? 0 : streak + 1;
        total++;
        if (instr_gnt !== exp_i || data_gnt !== !exp_i) begin
          bad++; $display("FAIL contention_order[%0d]: igt=%b dgt=%b want %b,%b",
                          n, instr_gnt, data_gnt, exp_i, !exp_i);
        end
        n++;
      end
      tick();
    end
    total++;
    if (n != 10) begin bad++; $display("FAIL contention_count: got %0d want 10", n); end
    instr_req = 0; data_req = 0;
    tick(); tick(); tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_delayed_store();
    data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
    tick();
    for (int c = 0; c < 4; c++) begin
      mem_gnt = (c == 3);
      #2;
      total++;
      if (mem_req !== 1 || {mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b0011, 32'h2000,
          32'hDEAD_BEEF} || data_gnt !== (c == 3) || data_stall !== 1) begin
        bad++;
        $display("FAIL store_req[%0d]: req=%b we=%b be=%b addr=%h wd=%h gnt=%b stall=%b", c,
                 mem_req, mem_we, mem_be, mem_addr, mem_wdata, data_gnt, data_stall);
      end
      tick();
    end
    data_req = 0; mem_gnt = 0;
    #2;
    total++;
    if (data_stall !== 1 || data_rvalid !== 0) begin
      bad++; $display("FAIL store_wait: stall=%b rvalid=%b want 1,0", data_stall, data_rvalid);
    end
    tick();
    mem_rvalid = 1;
    #2;
    total++;
    if (data_rvalid !== 1 || data_stall !== 0 || instr_rvalid !== 0) begin
      bad++; $display("FAIL store_resp: rvalid=%b stall=%b irv=%b want 1,0,0",
                      data_rvalid, data_stall, instr_rvalid);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_error();
    data_req = 1; data_we = 0; data_be = '1; data_addr = 32'h40;
    tick();
    mem_gnt = 1;
    tick();
    data_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_err = 1; mem_rdata = 32'hBAD;
    #2;
    total++;
    if (data_rvalid !== 1 || data_err !== 1 || instr_rvalid !== 0 || instr_err !== 0) begin
      bad++; $display("FAIL err_resp: drv=%b derr=%b irv=%b ierr=%b want 1,1,0,0",
                      data_rvalid, data_err, instr_rvalid, instr_err);
    end
    tick();
    #2;
    total++;
    if (data_rvalid !== 0 || data_err !== 0) begin
      bad++; $display("FAIL err_one_cycle: drv=%b derr=%b want 0,0", data_rvalid, data_err);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_in_resp();
    int n = 0;
    logic exp_i;
    instr_req = 1; instr_addr = 32'h500; data_req = 1; data_addr = 32'h600; data_be = '1;
    mem_gnt = 1; mem_rvalid = 1;
    // Four data wins push the starve count up to its limit.
    for (int c = 0; c < 20 && n < 4; c++) begin
      #2;
      if (instr_gnt || data_gnt) n++;
      tick();
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    #2;
    total++;
    if (busy !== 0 || instr_rvalid !== 0 || data_rvalid !== 0) begin
      bad++; $display("FAIL rst_resp: busy=%b irv=%b drv=%b want 0,0,0",
                      busy, instr_rvalid, data_rvalid);
    end
    tick();
    n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      #2;
      if (instr_gnt || data_gnt) begin
        exp_i = (n == LIM);
        total++;
        if (instr_gnt !== exp_i || data_gnt !== !exp_i) begin
          bad++; $display("FAIL rst_order[%0d]: igt=%b dgt=%b want %b,%b",
                          n, instr_gnt, data_gnt, exp_i, !exp_i);
        end
        n++;
      end
      tick();
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL rst_count: got %0d want 5", n); end
    instr_req = 0; data_req = 0;
    tick(); tick(); tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_stray_idle();
    mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++;
      if ({instr_gnt, data_gnt, instr_rvalid, data_rvalid, busy, mem_req} !== 6'b0) begin
        bad++; $display("FAIL stray[%0d]: got %b want 0", c,
                        {instr_gnt, data_gnt, instr_rvalid, data_rvalid, busy, mem_req});
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // Transaction-level model: one outstanding request, owner chosen by priority + starve rule.
  task automatic test_random();
    logic i_pend = 0, d_pend = 0;
    logic [AW-1:0] i_a;
    logic d_w;
    logic [DW/8-1:0] d_b;
    logic [AW-1:0] d_a;
    logic [DW-1:0] d_wd;
    logic m_busy = 0, m_granted = 0, m_instr = 0;
    logic [DW/8+AW+DW:0] m_fields = '0;
    int streak = 0;
    logic e_req, e_igt, e_dgt, fire, e_irv, e_drv, e_ist, e_dst, pick_i;
    logic [9:0] exp_v, got_v;
    for (int c = 0; c < 4000; c++) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin i_pend = 1; i_a = $urandom; end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_w = 1'($urandom); d_b = 4'($urandom); d_a = $urandom; d_wd = $urandom;
      end
      instr_req = i_pend; instr_addr = i_pend ? i_a : $urandom;
      data_req = d_pend; data_we = d_w; data_be = d_b; data_addr = d_a; data_wdata = d_wd;
      #1;
      mem_gnt = mem_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
      mem_rvalid = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom; mem_err = ($urandom_range(0, 3) == 0);
      #1;
      e_req = m_busy && !m_granted;
      e_igt = e_req && m_instr && mem_gnt;
      e_dgt = e_req && !m_instr && mem_gnt;
      fire = m_busy && m_granted && mem_rvalid;
      e_irv = fire && m_instr;
      e_drv = fire && !m_instr;
      e_ist = (i_pend && !e_igt) || (m_busy && m_instr && !fire);
      e_dst = (d_pend && !e_dgt) || (m_busy && !m_instr && !fire);
      exp_v = {e_req, e_igt, e_dgt, e_irv, e_drv, e_irv && mem_err, e_drv && mem_err,
               e_ist, e_dst, m_busy};
      got_v = {mem_req, instr_gnt, data_gnt, instr_rvalid, data_rvalid, instr_err, data_err,
               instr_stall, data_stall, busy};
      total++;
      if (got_v !== exp_v) begin
        bad++; $display("FAIL rand_ctrl[%0d]: got %b want %b", c, got_v, exp_v);
      end
      if (e_req) begin
        total++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== m_fields) begin
          bad++; $display("FAIL rand_fields[%0d]: got %h want %h", c,
                          {mem_we, mem_be, mem_addr, mem_wdata}, m_fields);
        end
      end
      if (fire) begin
        total++;
        if ((m_instr ? instr_rdata : data_rdata) !== mem_rdata) begin
          bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", c,
                          m_instr ? instr_rdata : data_rdata, mem_rdata);
        end
      end
      if (!m_busy) begin
        pick_i = i_pend && (!d_pend || streak == LIM);
        if (i_pend || d_pend) begin
          m_busy = 1; m_granted = 0; m_instr = pick_i;
          m_fields = pick_i ? {1'b0, 4'hF, i_a, 32'h0} : {d_w, d_b, d_a, d_wd};
        end
        streak = (!i_pend || pick_i) ? 0 : streak + 1;
      end else if (!m_granted) begin
        if (mem_gnt) m_granted = 1;
      end else if (mem_rvalid) begin
        m_busy = 0;
      end
      if (e_igt) i_pend = 0;
      if (e_dgt) d_pend = 0;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_contention();
    test_delayed_store();
    test_error();
    test_reset_in_resp();
    test_stray_idle();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
